nos_dac_rx: RTL and testbench

Deserializer for the NOS DAC serial stream (bck, data_l, data_r, le) produced by the NOS DAC transmitter in half mode. It samples the stream on the system clock and rebuilds the parallel stereo word in the same packed format the transmitter consumes. It then emits a one-cycle `valid` strobe with a frame-length error flag. It sits in the capture/loopback path for board bring-up and self-test, and in boards that receive an external NOS stream.

---
 rtl/common.sv | 40 ++++
 rtl/nos_rx_sync.sv | 35 +++
 rtl/nos_dac_rx.sv | 94 +++++++++
 tb/tb_nos_dac_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared NOS DAC definitions: stream widths, word-length select, receiver FSM states and
// word-length helpers used by both the transmitter and the receiver.
package common;

   localparam int unsigned I2S_BITS    = 32;
   localparam int unsigned NOS_SH_BITS = 24;

   typedef enum logic [1:0] {
      NOS16 = 2'd0,
      NOS18 = 2'd1,
      NOS20 = 2'd2,
      NOS24 = 2'd3
   } NOS_BITNUM;

   typedef enum logic [1:0] {
      RxIdle  = 2'd0,
      RxShift = 2'd1,
      RxLatch = 2'd2
   } nos_rx_state_e;

   function automatic logic [5:0] nos_bits(input NOS_BITNUM bitnum);
      logic [5:0] n;
      case (bitnum)
         NOS16:   n = 6'd16;
         NOS18:   n = 6'd18;
         NOS20:   n = 6'd20;
         default: n = 6'd24;
      endcase
      return n;
   endfunction

   // Keep the low N bits of a shift register, MSB-aligned in an I2S word, zero-filled below.
   function automatic logic [I2S_BITS-1:0] nos_align(input logic [NOS_SH_BITS-1:0] sh,
                                                    input NOS_BITNUM bitnum);
      logic [I2S_BITS-1:0] w;
      w = {sh, 8'b0};
      return w << (6'd24 - nos_bits(bitnum));
   endfunction

endpackage

// File: rtl/nos_rx_sync.sv
// Input conditioner for the NOS receiver: 2-flop synchronizers when NOS_DAC_RX_SYNC_EN is
// defined, otherwise a pass-through; plus delayed copies of bck and le for edge detection.
module nos_rx_sync (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] raw,      // {bck, le, data_l, data_r}
   output logic [3:0] smp,      // sampled copies, same order
   output logic [1:0] dly       // {bck_d, le_d}
);

`ifdef NOS_DAC_RX_SYNC_EN
   logic [3:0] meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= '0;
         smp  <= '0;
      end else begin
         meta <= raw;
         smp  <= meta;
      end
   end
`else
   assign smp = raw;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dly <= '0;
      end else begin
         dly <= smp[3:2];
      end
   end

endmodule

// File: rtl/nos_dac_rx.sv
// NOS DAC serial stream deserializer: rebuilds the packed stereo word and strobes valid with a
// short-frame error flag. Define NOS_DAC_RX_SYNC_EN to synchronize an asynchronous source.
module nos_dac_rx
   import common::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  bck,
   input  logic                  data_l,
   input  logic                  data_r,
   input  logic                  le,
   input  NOS_BITNUM             nos_bitnum,
   output logic [2*I2S_BITS-1:0] data,
   output logic                  valid,
   output logic                  frame_err,
   output logic [5:0]            bits_seen
);

   logic [3:0] smp;
   logic [1:0] dly;
   logic       bck_s, le_s, dl_s, dr_s;
   logic       bck_d, le_d;
   logic       bck_rise, le_rise;

   logic [NOS_SH_BITS-1:0] sh_l, sh_r;
   logic [5:0]             cnt;
   logic [5:0]             cnt_inc;
   nos_rx_state_e          state;

   nos_rx_sync u_sync (
      .clk    (clk),
      .resetn (resetn),
      .raw    ({bck, le, data_l, data_r}),
      .smp    (smp),
      .dly    (dly)
   );

   assign {bck_s, le_s, dl_s, dr_s} = smp;
   assign {bck_d, le_d}             = dly;

   assign bck_rise = bck_s & ~bck_d;
   assign le_rise  = le_s & ~le_d;
   assign cnt_inc  = (cnt == 6'd63) ? cnt : cnt + 6'd1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= RxIdle;
         sh_l      <= '0;
         sh_r      <= '0;
         cnt       <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         bits_seen <= '0;
      end else begin
         valid <= 1'b0;
         // le_rise implies le_s high, so a coincident bck_rise is the latch pulse, not data.
         if (le_rise) begin
            data      <= {nos_align(sh_l, nos_bitnum), nos_align(sh_r, nos_bitnum)};
            frame_err <= (cnt < nos_bits(nos_bitnum));
            bits_seen <= cnt;
            valid     <= 1'b1;
            state     <= RxLatch;
         end else begin
            case (state)
               RxIdle, RxShift: begin
                  if (bck_rise && !le_s) begin
                     sh_l  <= {sh_l[NOS_SH_BITS-2:0], dl_s};
                     sh_r  <= {sh_r[NOS_SH_BITS-2:0], dr_s};
                     cnt   <= cnt_inc;
                     state <= RxShift;
                  end
               end
               RxLatch: begin
                  if (!le_s) begin
                     // A data edge coinciding with le falling starts the next frame directly.
                     if (bck_rise) begin
                        sh_l  <= {sh_l[NOS_SH_BITS-2:0], dl_s};
                        sh_r  <= {sh_r[NOS_SH_BITS-2:0], dr_s};
                        cnt   <= 6'd1;
                        state <= RxShift;
                     end else begin
                        cnt   <= '0;
                        state <= RxIdle;
                     end
                  end
               end
               default: state <= RxIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nos_dac_rx.sv
// Self-checking bench for nos_dac_rx: table vectors, reset corner case and random frames
// checked against a bit-history reference model.
module tb_nos_dac_rx;
   import common::*;

`ifdef NOS_DAC_RX_SYNC_EN
   localparam int LAT   = 3;
   localparam int HPMIN = 2;
`else
   localparam int LAT   = 1;
   localparam int HPMIN = 1;
`endif

   logic        clk = 1'b0;
   logic        resetn, bck, data_l, data_r, le;
   NOS_BITNUM   nos_bitnum;
   logic [63:0] data;
   logic        valid, frame_err;
   logic [5:0]  bits_seen;

   nos_dac_rx dut (
      .clk        (clk),
      .resetn     (resetn),
      .bck        (bck),
      .data_l     (data_l),
      .data_r     (data_r),
      .le         (le),
      .nos_bitnum (nos_bitnum),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err),
      .bits_seen  (bits_seen)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      logic        err;
      logic [5:0]  bits;
      int          c;
   } cap_t;

   cap_t vq[$];
   always @(negedge clk) begin
      cap_t e;
      if (valid === 1'b1) begin
         e.data = data;
         e.err  = frame_err;
         e.bits = bits_seen;
         e.c    = cyc;
         vq.push_back(e);
      end
   end

   bit hl[$];
   bit hr[$];
   int checks = 0;
   int errors = 0;
   int le_cyc = 0;
   int frame_bits = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int nbits_of(input NOS_BITNUM b);
      case (b)
         NOS16:   return 16;
         NOS18:   return 18;
         NOS20:   return 20;
         default: return 24;
      endcase
   endfunction

   // Last n bits ever shifted on one channel, MSB-aligned; missing history reads as zero.
   function automatic logic [31:0] model_word(input bit left, input int n);
      logic [31:0] v;
      int          idx;
      bit          b;
      v = '0;
      for (int k = 0; k < n; k++) begin
         idx = (left ? hl.size() : hr.size()) - n + k;
         b   = 1'b0;
         if (idx >= 0) b = left ? hl[idx] : hr[idx];
         v = {v[30:0], b};
      end
      return v << (32 - n);
   endfunction

   task automatic put_bit(input bit l, input bit r, input int hp);
      bck    = 1'b0;
      data_l = l;
      data_r = r;
      tick(hp);
      bck = 1'b1;
      tick(hp);
      hl.push_back(l);
      hr.push_back(r);
      frame_bits++;
   endtask

   // lmode 0: plain le pulse; 1: extra bck pulse while le is high; 2: bck and le rise together
   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int ndata,
                             input int ndummy, input NOS_BITNUM nsel, input int lmode,
                             input int hp);
      nos_bitnum = nsel;
      frame_bits = 0;
      for (int i = 0; i < ndummy; i++) put_bit(1'b0, 1'b0, hp);
      for (int i = 0; i < ndata; i++) put_bit(lw[31-i], rw[31-i], hp);
      bck    = 1'b0;
      data_l = 1'b0;
      data_r = 1'b0;
      tick(hp);
      le     = 1'b1;
      le_cyc = cyc;
      if (lmode == 2) begin
         bck = 1'b1;
         tick(hp);
         bck = 1'b0;
         tick(hp);
      end else if (lmode == 1) begin
         tick(hp);
         bck = 1'b1;
         tick(hp);
         bck = 1'b0;
         tick(hp);
      end else begin
         tick(2 * hp);
      end
      le = 1'b0;
      tick(2 * hp + 2);
   endtask

   task automatic check_model(input string name, input NOS_BITNUM nsel);
      int          n, mcnt;
      logic [63:0] md;
      cap_t        e;
      n    = nbits_of(nsel);
      md   = {model_word(1'b1, n), model_word(1'b0, n)};
      mcnt = (frame_bits > 63) ? 63 : frame_bits;
      chk({name, " valid_count"}, vq.size(), 1);
      if (vq.size() > 0) begin
         e = vq.pop_front();
         chk({name, " data"}, e.data, md);
         chk({name, " frame_err"}, e.err, (mcnt < n));
         chk({name, " bits_seen"}, e.bits, mcnt);
         chk({name, " latency"}, e.c - le_cyc, LAT);
         chk({name, " hold"}, data, e.data);
      end
      vq.delete();
   endtask

   typedef struct {
      logic [31:0] lw, rw;
      NOS_BITNUM   nsel;
      int          ndata, ndummy, lmode, hp;
      logic [63:0] exp_data;
      bit          chk_data;
      bit          exp_err;
      logic [5:0]  exp_bits;
   } vec_t;

   vec_t tab[11];

   initial begin
      tab[0]  = '{32'hA5A5_0000, 32'h1234_0000, NOS16, 16, 0, 0, HPMIN,
                  64'hA5A5_0000_1234_0000, 1'b1, 1'b0, 6'd16};
      tab[1]  = '{32'h8000_0100, 32'h7FFF_FF00, NOS24, 24, 7, 0, HPMIN + 1,
                  64'h8000_0100_7FFF_FF00, 1'b1, 1'b0, 6'd31};
      tab[2]  = '{32'h1234_0000, 32'hFFFF_C000, NOS18, 18, 0, 0, HPMIN,
                  64'h1234_0000_FFFF_C000, 1'b1, 1'b0, 6'd18};
      tab[3]  = '{32'hABCD_E000, 32'hFFFF_F000, NOS20, 20, 0, 0, HPMIN,
                  64'hABCD_E000_FFFF_F000, 1'b1, 1'b0, 6'd20};
      tab[4]  = '{32'hFFC0_0000, 32'h0000_0000, NOS16, 10, 0, 0, HPMIN,
                  64'h7BFF_0000_FC00_0000, 1'b1, 1'b1, 6'd10};
      tab[5]  = '{32'h0, 32'h0, NOS24, 0, 0, 0, HPMIN, 64'h0, 1'b0, 1'b1, 6'd0};
      tab[6]  = '{32'h0FED_CBA0, 32'h1234_567F, NOS24, 28, 0, 0, HPMIN,
                  64'hFEDC_BA00_2345_6700, 1'b1, 1'b0, 6'd28};
      tab[7]  = '{32'hBEEF_0000, 32'hCAFE_0000, NOS16, 16, 0, 1, HPMIN,
                  64'hBEEF_0000_CAFE_0000, 1'b1, 1'b0, 6'd16};
      tab[8]  = '{32'h1357_0000, 32'h2468_0000, NOS16, 16, 0, 2, HPMIN,
                  64'h1357_0000_2468_0000, 1'b1, 1'b0, 6'd16};
      tab[9]  = '{32'hC3C3_C300, 32'h3C3C_3C00, NOS24, 24, 40, 0, HPMIN,
                  64'hC3C3_C300_3C3C_3C00, 1'b1, 1'b0, 6'd63};
      tab[10] = '{32'hFFFF_F000, 32'h0000_1000, NOS20, 19, 0, 0, HPMIN,
                  64'h0, 1'b0, 1'b1, 6'd19};

      resetn     = 1'b0;
      bck        = 1'b0;
      le         = 1'b0;
      data_l     = 1'b0;
      data_r     = 1'b0;
      nos_bitnum = NOS16;
      tick(3);
      chk("reset data", data, 64'h0);
      chk("reset valid", valid, 1'b0);
      chk("reset frame_err", frame_err, 1'b0);
      chk("reset bits_seen", bits_seen, 6'd0);
      resetn = 1'b1;
      tick(2);

      foreach (tab[i]) begin
         cap_t e;
         send_frame(tab[i].lw, tab[i].rw, tab[i].ndata, tab[i].ndummy, tab[i].nsel,
                    tab[i].lmode, tab[i].hp);
         if (vq.size() > 0) begin
            e = vq[0];
            if (tab[i].chk_data) chk($sformatf("vec%0d data", i), e.data, tab[i].exp_data);
            chk($sformatf("vec%0d err", i), e.err, tab[i].exp_err);
            chk($sformatf("vec%0d bits", i), e.bits, tab[i].exp_bits);
         end
         check_model($sformatf("vec%0d model", i), tab[i].nsel);
      end

      // Reset halfway through a frame: no valid for the partial frame, everything cleared.
      nos_bitnum = NOS16;
      frame_bits = 0;
      for (int i = 0; i < 8; i++) put_bit(1'b1, 1'b1, HPMIN);
      bck    = 1'b0;
      resetn = 1'b0;
      #1;
      chk("midreset data", data, 64'h0);
      chk("midreset bits_seen", bits_seen, 6'd0);
      tick(2);
      resetn = 1'b1;
      hl.delete();
      hr.delete();
      tick(2);
      chk("midreset no_valid", vq.size(), 0);
      send_frame(32'h0001_0000, 32'h8001_0000, 16, 0, NOS16, 0, HPMIN);
      if (vq.size() > 0) chk("postreset left", vq[0].data[63:48], 16'h0001);
      check_model("postreset model", NOS16);

      for (int i = 0; i < 25; i++) begin
         NOS_BITNUM ns;
         ns = NOS_BITNUM'($urandom_range(0, 3));
         send_frame($urandom, $urandom, $urandom_range(0, 32), $urandom_range(0, 4), ns,
                    $urandom_range(0, 2), $urandom_range(HPMIN, HPMIN + 2));
         check_model($sformatf("rand%0d", i), ns);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
